// File: rtl/ps2_key_decoder_if.sv
// Byte-strobe input and decoded key-event outputs of the PS/2 key decoder.
// master drives the byte stream and flush; slave is the decoder.
interface ps2_key_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       flush;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] last_make;
    logic [3:0] dir_held;

    modport master (
        output received_data, received_data_en, flush,
        input  key_event, key_code, key_ext, key_break, last_make, dir_held
    );

    modport slave (
        input  received_data, received_data_en, flush,
        output key_event, key_code, key_ext, key_break, last_make, dir_held
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 scan-code bytes (E0/F0 prefixes) into key events, last make code and a held-direction mask.
// Latency 1 cycle from the final byte strobe; no backpressure, every strobed byte is consumed.
module ps2_key_decoder #(
    parameter int TIMEOUT = 50000
) (
    input  logic             clock,
    input  logic             resetn,
    ps2_key_decoder_if.slave bus
);
    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [7:0]    B_E0 = 8'hE0;
    localparam logic [7:0]    B_F0 = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic          w_byte;
    logic          w_prefix;
    logic          w_done;
    logic          w_ext;
    logic          w_brk;
    logic [3:0]    w_dir_bit;

    logic          r_key_event;
    logic [7:0]    r_key_code;
    logic          r_key_ext;
    logic          r_key_break;
    logic [7:0]    r_last_make;
    logic [3:0]    r_dir_held;

    // A byte coinciding with flush is dropped entirely.
    assign w_byte   = bus.received_data_en && !bus.flush;
    assign w_prefix = (bus.received_data == B_E0) || (bus.received_data == B_F0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = IDLE;
        end else if (bus.received_data_en) begin
            case (r_state)
                IDLE:    if (bus.received_data == B_F0)      w_next_state = BRK;
                         else if (bus.received_data == B_E0) w_next_state = EXT;
                EXT:     if (bus.received_data == B_F0)      w_next_state = EXT_BRK;
                         else if (bus.received_data != B_E0) w_next_state = IDLE;
                BRK:     if (bus.received_data == B_E0)      w_next_state = EXT;
                         else if (bus.received_data != B_F0) w_next_state = IDLE;
                EXT_BRK: if (!w_prefix)                      w_next_state = IDLE;
                default:                                     w_next_state = IDLE;
            endcase
        end else if (r_state != IDLE && r_timer == TMAX) begin
            w_next_state = IDLE;
        end
    end

    always_comb begin
        w_done = w_byte && !w_prefix;
        w_ext  = (r_state == EXT) || (r_state == EXT_BRK);
        w_brk  = (r_state == BRK) || (r_state == EXT_BRK);
    end

    // Arrow keys arrive extended, WASD arrive plain; extended WASD codes are other keys.
    always_comb begin
        case ({w_ext, bus.received_data})
            9'h175, 9'h01D: w_dir_bit = 4'b1000;
            9'h172, 9'h01B: w_dir_bit = 4'b0100;
            9'h16B, 9'h01C: w_dir_bit = 4'b0010;
            9'h174, 9'h023: w_dir_bit = 4'b0001;
            default:        w_dir_bit = 4'b0000;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                               r_timer <= '0;
        else if (w_byte || w_next_state == IDLE)   r_timer <= '0;
        else                                       r_timer <= r_timer + TW'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_key_event <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_last_make <= 8'h00;
            r_dir_held  <= 4'b0000;
        end else begin
            r_key_event <= w_done;
            if (bus.flush) begin
                r_dir_held <= 4'b0000;
            end else if (w_done) begin
                r_key_code  <= bus.received_data;
                r_key_ext   <= w_ext;
                r_key_break <= w_brk;
                if (!w_brk) r_last_make <= bus.received_data;
                r_dir_held  <= w_brk ? (r_dir_held & ~w_dir_bit) : (r_dir_held | w_dir_bit);
            end
        end
    end

    assign bus.key_event = r_key_event;
    assign bus.key_code  = r_key_code;
    assign bus.key_ext   = r_key_ext;
    assign bus.key_break = r_key_break;
    assign bus.last_make = r_last_make;
    assign bus.dir_held  = r_dir_held;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with TIMEOUT=16.
module tb_ps2_key_decoder;
    logic clock;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   ev_count = 0;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.TIMEOUT(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (bus.key_event === 1'b1) ev_count++;

    // Caller sits just after a negedge; byte is sampled on the next posedge.
    task automatic send_byte(input logic [7:0] b);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(negedge clock);
        bus.received_data_en = 1'b0;
        bus.received_data    = 8'h00;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        bus.received_data = 8'h00; bus.received_data_en = 1'b0; bus.flush = 1'b0;
        #1;
        checks++; if (bus.key_event !== 1'b0) begin errors++; $display("FAIL rst_event got %b exp 0", bus.key_event); end
        checks++; if (bus.key_code !== 8'h00) begin errors++; $display("FAIL rst_code got %h exp 00", bus.key_code); end
        checks++; if (bus.key_ext !== 1'b0) begin errors++; $display("FAIL rst_ext got %b exp 0", bus.key_ext); end
        checks++; if (bus.key_break !== 1'b0) begin errors++; $display("FAIL rst_break got %b exp 0", bus.key_break); end
        checks++; if (bus.last_make !== 8'h00) begin errors++; $display("FAIL rst_last got %h exp 00", bus.last_make); end
        checks++; if (bus.dir_held !== 4'b0000) begin errors++; $display("FAIL rst_dir got %b exp 0000", bus.dir_held); end
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_ext_make;
        int ev0;
        ev0 = ev_count;
        send_byte(8'hE0);
        checks++; if (bus.key_event !== 1'b0) begin errors++; $display("FAIL e0_no_event got %b exp 0", bus.key_event); end
        send_byte(8'h75);
        checks++; if (bus.key_event !== 1'b1) begin errors++; $display("FAIL up_event got %b exp 1", bus.key_event); end
        checks++; if (bus.key_code !== 8'h75) begin errors++; $display("FAIL up_code got %h exp 75", bus.key_code); end
        checks++; if (bus.key_ext !== 1'b1) begin errors++; $display("FAIL up_ext got %b exp 1", bus.key_ext); end
        checks++; if (bus.key_break !== 1'b0) begin errors++; $display("FAIL up_break got %b exp 0", bus.key_break); end
        checks++; if (bus.dir_held !== 4'b1000) begin errors++; $display("FAIL up_dir got %b exp 1000", bus.dir_held); end
        checks++; if (bus.last_make !== 8'h75) begin errors++; $display("FAIL up_last got %h exp 75", bus.last_make); end
        idle(1);
        checks++; if (bus.key_event !== 1'b0) begin errors++; $display("FAIL up_pulse_width got %b exp 0", bus.key_event); end
        checks++; if (ev_count - ev0 !== 1) begin errors++; $display("FAIL up_count got %0d exp 1", ev_count - ev0); end
    endtask

    task automatic test_ext_break;
        int ev0;
        ev0 = ev_count;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++; if (bus.key_event !== 1'b1) begin errors++; $display("FAIL upbrk_event got %b exp 1", bus.key_event); end
        checks++; if (bus.key_break !== 1'b1) begin errors++; $display("FAIL upbrk_break got %b exp 1", bus.key_break); end
        checks++; if (bus.key_ext !== 1'b1) begin errors++; $display("FAIL upbrk_ext got %b exp 1", bus.key_ext); end
        checks++; if (bus.dir_held !== 4'b0000) begin errors++; $display("FAIL upbrk_dir got %b exp 0000", bus.dir_held); end
        checks++; if (bus.last_make !== 8'h75) begin errors++; $display("FAIL upbrk_last got %h exp 75", bus.last_make); end
        idle(1);
        checks++; if (ev_count - ev0 !== 1) begin errors++; $display("FAIL upbrk_count got %0d exp 1", ev_count - ev0); end
    endtask

    task automatic test_wasd;
        int ev0;
        ev0 = ev_count;
        send_byte(8'h1C);
        checks++; if (bus.dir_held !== 4'b0010) begin errors++; $display("FAIL a_dir got %b exp 0010", bus.dir_held); end
        send_byte(8'h23);
        checks++; if (bus.dir_held !== 4'b0011) begin errors++; $display("FAIL ad_dir got %b exp 0011", bus.dir_held); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++; if (bus.dir_held !== 4'b0001) begin errors++; $display("FAIL abrk_dir got %b exp 0001", bus.dir_held); end
        checks++; if (bus.last_make !== 8'h23) begin errors++; $display("FAIL abrk_last got %h exp 23", bus.last_make); end
        checks++; if (ev_count - ev0 !== 3) begin errors++; $display("FAIL wasd_count got %0d exp 3", ev_count - ev0); end
        send_byte(8'h23);
        checks++; if (bus.key_event !== 1'b1 || bus.dir_held !== 4'b0001) begin errors++; $display("FAIL repeat_make got ev %b dir %b exp 1 0001", bus.key_event, bus.dir_held); end
        send_byte(8'hF0);
        send_byte(8'h1D);
        checks++; if (bus.key_event !== 1'b1 || bus.dir_held !== 4'b0001) begin errors++; $display("FAIL unheld_brk got ev %b dir %b exp 1 0001", bus.key_event, bus.dir_held); end
        send_byte(8'h1B);
        checks++; if (bus.dir_held !== 4'b0101) begin errors++; $display("FAIL s_dir got %b exp 0101", bus.dir_held); end
        send_byte(8'hF0);
        send_byte(8'h23);
        send_byte(8'hF0);
        send_byte(8'h1B);
        checks++; if (bus.dir_held !== 4'b0000) begin errors++; $display("FAIL wasd_clear got %b exp 0000", bus.dir_held); end
    endtask

    task automatic test_timeout;
        int ev0;
        ev0 = ev_count;
        send_byte(8'hE0);
        idle(20);
        checks++; if (ev_count - ev0 !== 0) begin errors++; $display("FAIL to_no_event got %0d exp 0", ev_count - ev0); end
        send_byte(8'h6B);
        checks++; if (bus.key_event !== 1'b1) begin errors++; $display("FAIL to_event got %b exp 1", bus.key_event); end
        checks++; if (bus.key_code !== 8'h6B) begin errors++; $display("FAIL to_code got %h exp 6B", bus.key_code); end
        checks++; if (bus.key_ext !== 1'b0) begin errors++; $display("FAIL to_ext got %b exp 0", bus.key_ext); end
        checks++; if (bus.dir_held !== 4'b0000) begin errors++; $display("FAIL to_dir got %b exp 0000", bus.dir_held); end
        // Byte on the expiry cycle is still decoded as extended.
        send_byte(8'hE0);
        idle(15);
        send_byte(8'h5A);
        checks++; if (bus.key_event !== 1'b1 || bus.key_ext !== 1'b1) begin errors++; $display("FAIL to_edge_ext got ev %b ext %b exp 1 1", bus.key_event, bus.key_ext); end
        send_byte(8'hE0);
        idle(16);
        send_byte(8'h5A);
        checks++; if (bus.key_event !== 1'b1 || bus.key_ext !== 1'b0) begin errors++; $display("FAIL to_past_ext got ev %b ext %b exp 1 0", bus.key_event, bus.key_ext); end
    endtask

    task automatic test_flush;
        int ev0;
        send_byte(8'h1D);
        checks++; if (bus.dir_held !== 4'b1000) begin errors++; $display("FAIL w_dir got %b exp 1000", bus.dir_held); end
        ev0 = ev_count;
        bus.flush = 1'b1;
        send_byte(8'hF0);
        bus.flush = 1'b0;
        checks++; if (bus.dir_held !== 4'b0000) begin errors++; $display("FAIL flush_dir got %b exp 0000", bus.dir_held); end
        checks++; if (bus.key_event !== 1'b0) begin errors++; $display("FAIL flush_event got %b exp 0", bus.key_event); end
        checks++; if (bus.key_code !== 8'h1D || bus.last_make !== 8'h1D) begin errors++; $display("FAIL flush_retain got code %h last %h exp 1D 1D", bus.key_code, bus.last_make); end
        send_byte(8'h1D);
        checks++; if (bus.dir_held !== 4'b1000 || bus.key_break !== 1'b0) begin errors++; $display("FAIL post_flush got dir %b brk %b exp 1000 0", bus.dir_held, bus.key_break); end
        checks++; if (ev_count - ev0 !== 1) begin errors++; $display("FAIL flush_count got %0d exp 1", ev_count - ev0); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'hE0);
        resetn = 1'b0;
        #1;
        checks++; if (bus.key_code !== 8'h00 || bus.last_make !== 8'h00 || bus.dir_held !== 4'b0000) begin errors++; $display("FAIL mid_rst_outs got code %h last %h dir %b exp 00 00 0000", bus.key_code, bus.last_make, bus.dir_held); end
        idle(3);
        checks++; if (bus.key_event !== 1'b0 || bus.key_ext !== 1'b0 || bus.key_break !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got ev %b ext %b brk %b exp 0 0 0", bus.key_event, bus.key_ext, bus.key_break); end
        resetn = 1'b1;
        send_byte(8'h74);
        checks++; if (bus.key_event !== 1'b1 || bus.key_code !== 8'h74) begin errors++; $display("FAIL mid_rst_make got ev %b code %h exp 1 74", bus.key_event, bus.key_code); end
        checks++; if (bus.key_ext !== 1'b0 || bus.dir_held !== 4'b0000) begin errors++; $display("FAIL mid_rst_ext got ext %b dir %b exp 0 0000", bus.key_ext, bus.dir_held); end
    endtask

    initial begin
        test_reset();
        test_ext_make();
        test_ext_break();
        test_wasd();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, the number of clock cycles a partial prefix sequence may wait for its next byte (1 ms at 50 MHz).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port received_data, input, 8, the PS/2 byte from the PS2 controller.
REQ-005 SHALL have port received_data_en, input, 1, a one-cycle strobe marking received_data valid.
REQ-006 SHALL have port flush, input, 1, a synchronous active-high clear of decode state and held keys.
REQ-007 SHALL have port key_event, output, 1, a one-cycle pulse marking a completed key make or break.
REQ-008 SHALL have port key_code, output, 8, the final scan code of the last completed event.
REQ-009 SHALL have port key_ext, output, 1, which is 1 when the last event carried an E0 prefix.
REQ-010 SHALL have port key_break, output, 1, which is 1 when the last event was a release (F0).
REQ-011 SHALL have port last_make, output, 8, the scan code of the most recent non-extended or extended make, fed to m_playing as last_key_received.
REQ-012 SHALL have port dir_held, output, 4, the held-direction mask: [3] up, [2] down, [1] left, [0] right.

Function
REQ-013 SHALL implement the states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-014 SHALL take these transitions from IDLE: byte F0 -> BRK; byte E0 -> EXT; any other byte -> complete a make with ext=0 and stay in IDLE.
REQ-015 SHALL take these transitions from EXT: F0 -> EXT_BRK; E0 -> stay in EXT and restart the timer; any other byte -> complete a make with ext=1 and go to IDLE.
REQ-016 SHALL take these transitions from BRK: E0 -> EXT; F0 -> stay in BRK and restart the timer; any other byte -> complete a break with ext=0 and go to IDLE.
REQ-017 SHALL take these transitions from EXT_BRK: E0 or F0 -> stay in EXT_BRK and restart the timer; any other byte -> complete a break with ext=1 and go to IDLE.
REQ-018 SHALL, on event completion, register key_code, key_ext and key_break and pulse key_event high for exactly one cycle on the clock edge that samples the final received_data_en (1-cycle latency).
REQ-019 SHALL hold key_code, key_ext and key_break stable between events.
REQ-020 SHALL, on completion of a make only, update last_make to the final byte; breaks SHALL leave last_make unchanged.
REQ-021 SHALL use these direction keys: up = E0 75 or 1D (W); down = E0 72 or 1B (S); left = E0 6B or 1C (A); right = E0 74 or 23 (D).
REQ-022 SHALL set the matching dir_held bit on a direction make and clear it on a direction break; other codes SHALL leave dir_held unchanged.
REQ-023 SHALL still pulse key_event on a repeated typematic make while the bit is already set, with dir_held unchanged.
REQ-024 SHALL still pulse key_event on a break of a key that is not held, with dir_held unchanged.
REQ-025 SHALL allow opposing directions to be held simultaneously; dir_held reports both with no priority resolution.
REQ-026 SHALL run a timeout counter of width clog2(TIMEOUT) in any non-IDLE state; the counter resets to 0 on every accepted byte and on entry to IDLE.
REQ-027 SHALL, when the counter reaches TIMEOUT-1 with no byte, return to IDLE on the next edge with no key_event and no dir_held change.
REQ-028 SHALL, when a byte arrives in the same cycle as timeout expiry, process the byte against the current state; the timeout is ignored.
REQ-029 SHALL, on flush=1, force IDLE, clear dir_held and the timer, and suppress key_event; a byte in the same cycle SHALL be discarded; key_code, key_ext, key_break and last_make SHALL be retained.
REQ-030 SHALL ignore received_data whenever received_data_en=0.

Reset
REQ-031 SHALL, on resetn=0, immediately and asynchronously force the state to IDLE and set key_event=0, key_code=8'h00, key_ext=0, key_break=0, last_make=8'h00, dir_held=4'b0000 and the timer to 0.
REQ-032 SHALL, on reset asserted mid-sequence (e.g. after E0), discard the partial sequence so that the first byte after release is decoded from IDLE.

Verification
REQ-033 SHALL cover: bytes E0, 75 -> one key_event with key_code=75, key_ext=1, key_break=0, dir_held=1000, last_make=75.
REQ-034 SHALL cover: then bytes E0, F0, 75 -> one key_event with key_break=1, key_ext=1, dir_held=0000, last_make still 75.
REQ-035 SHALL cover: bytes 1C, 23, then F0 1C -> dir_held sequence 0010, 0011, 0001, with three key_event pulses.
REQ-036 SHALL cover: TIMEOUT=16, byte E0 then idle 20 cycles, then 6B -> no event from the E0; 6B decodes as a non-extended make with key_ext=0 and dir_held=0000.
REQ-037 SHALL cover: 1D held (dir_held=1000), then flush pulse concurrent with byte F0 -> dir_held=0000, no key_event; a following byte 1D sets dir_held=1000 again.
REQ-038 SHALL cover: byte E0 then resetn low for 3 cycles, then 74 -> all outputs zero during reset; 74 yields key_ext=0 and dir_held=0000.
